log_scheduler: RTL and testbench

LOG_SCHEDULER -- requirements
Module: log_scheduler

---
 rtl/log_scheduler.sv | 128 ++++++++++++
 tb/tb_log_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/log_scheduler.sv
// Two-requester byte logger: round-robin arbitration into a FIFO drained one byte per
// EEPROM-writer window. Optional LOG_TAG_EN tags each stored byte with its source in bit 7.
module log_scheduler #(
  parameter int          DEPTH = 8,
  parameter logic [7:0]  PAD   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_a,
  output logic       ack_b,
  input  logic       ready4NewData,
  input  logic       done,
  output logic [7:0] writeData,
  output logic [3:0] fifo_count,
  output logic       underrun,
  output logic       log_full,
  output logic [1:0] state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {HOLD = 2'd0, LOAD = 2'd1, FINISHED = 2'd2} state_t;

  // Handshake: a requester holds req high with stable data; ack is a one-cycle
  // grant and the byte is captured on the clock edge that ends the ack cycle.

  state_t          state, state_nx;
  logic            rdy_s1, rdy_s2, rdy_prev, done_s1, done_s2;
  logic            rise, pop, push, eligible, ptr_b, last_a, last_b;
  logic            want_a, want_b;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [7:0]      push_byte;

  assign rise       = rdy_s2 & ~rdy_prev;
  assign pop        = (state == LOAD) && (cnt != '0);
  assign push       = ack_a | ack_b;
  assign eligible   = (state != FINISHED) && ((cnt < CW'(DEPTH)) || pop);
  assign want_a     = req_a & ~last_a;
  assign want_b     = req_b & ~last_b;
  assign fifo_count = 4'(cnt);
  assign log_full   = done_s2;
  assign state_dbg  = state;

  always_comb begin
    state_nx = state;
    case (state)
      HOLD:     if (done_s2) state_nx = FINISHED;
                else if (rise) state_nx = LOAD;
      LOAD:     state_nx = done_s2 ? FINISHED : HOLD;
      FINISHED: state_nx = FINISHED;
      default:  state_nx = HOLD;
    endcase
  end

  always_comb begin
    ack_a = 1'b0;
    ack_b = 1'b0;
    if (eligible) begin
      if (want_a && want_b) begin
        ack_a = ~ptr_b;
        ack_b = ptr_b;
      end else begin
        ack_a = want_a;
        ack_b = want_b;
      end
    end
  end

`ifdef LOG_TAG_EN
  assign push_byte = ack_b ? {1'b1, data_b[6:0]} : {1'b0, data_a[6:0]};
`else
  assign push_byte = ack_b ? data_b : data_a;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      rdy_s1    <= 1'b0;
      rdy_s2    <= 1'b0;
      rdy_prev  <= 1'b0;
      done_s1   <= 1'b0;
      done_s2   <= 1'b0;
      ptr_b     <= 1'b0;
      last_a    <= 1'b0;
      last_b    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      writeData <= PAD;
      underrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      rdy_s1   <= ready4NewData;
      rdy_s2   <= rdy_s1;
      rdy_prev <= rdy_s2;
      done_s1  <= done;
      done_s2  <= done_s1;
      last_a   <= ack_a;
      last_b   <= ack_b;
      // Pointer only moves when both were competing for the grant.
      if (push && req_a && req_b) ptr_b <= ack_a;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (state == LOAD) begin
        if (pop) writeData <= mem[rd_ptr];
        else begin
          writeData <= PAD;
          underrun  <= 1'b1;
        end
      end
    end
  end

  // Storage needs no reset; read-before-write keeps the head intact when full.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

endmodule

// File: tb/tb_log_scheduler.sv
// Directed bench for log_scheduler: grants, FIFO order, full/underrun boundaries,
// done freeze and reset behaviour.
module tb_log_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, ready4NewData, done;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, underrun, log_full;
  logic [7:0] writeData;
  logic [3:0] fifo_count;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

`ifdef LOG_TAG_EN
  localparam logic [7:0] EXP_A_FF = 8'h7F;
`else
  localparam logic [7:0] EXP_A_FF = 8'hFF;
`endif

  always #5 clk = ~clk;

  log_scheduler #(.DEPTH(8), .PAD(8'hFF)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b), .ready4NewData(ready4NewData), .done(done),
    .writeData(writeData), .fifo_count(fifo_count), .underrun(underrun),
    .log_full(log_full), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; one grant cycle then one idle cycle.
  task automatic push(input bit src_b, input logic [7:0] d);
    if (src_b) begin req_b = 1'b1; data_b = d; end
    else       begin req_a = 1'b1; data_a = d; end
    #1;
    chk(src_b ? "push_ack_b" : "push_ack_a", 32'(src_b ? ack_b : ack_a), 32'h1);
    tick(1);
    req_a = 1'b0;
    req_b = 1'b0;
    tick(1);
  endtask

  // Four edges with ready high cover sync (2), LOAD entry and the load edge.
  task automatic pulse();
    ready4NewData = 1'b1;
    tick(4);
    ready4NewData = 1'b0;
    tick(3);
    #1;
  endtask

  task automatic drain_check(input string tag);
    pulse();
    chk(tag, 32'(writeData), 32'(exp_q.pop_front()));
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
    ready4NewData = 1'b0; done = 1'b0;
    tick(2);
    #1;
    chk("rst_wd", 32'(writeData), 32'hFF);
    chk("rst_ack", 32'({ack_a, ack_b}), 32'h0);
    chk("rst_cnt", 32'(fifo_count), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_logfull", 32'(log_full), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Single byte through the FIFO; writeData moves on the 4th edge after ready.
    push(1'b0, 8'h12);
    #1 chk("t1_cnt1", 32'(fifo_count), 32'h1);
    ready4NewData = 1'b1;
    tick(3);
    #1;
    chk("t1_state_load", 32'(state_dbg), 32'h1);
    chk("t1_wd_held", 32'(writeData), 32'hFF);
    tick(1);
    #1;
    chk("t1_wd", 32'(writeData), 32'h12);
    chk("t1_cnt0", 32'(fifo_count), 32'h0);
    ready4NewData = 1'b0;
    tick(3);

    // Both requesting continuously: A, B, A, B.
    req_a = 1'b1; data_a = 8'hA1;
    req_b = 1'b1; data_b = 8'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_ack_a", 32'(ack_a), 32'((i % 2) == 0));
      chk("t2_ack_b", 32'(ack_b), 32'((i % 2) == 1));
      tick(1);
    end
    req_a = 1'b0; req_b = 1'b0;
    #1 chk("t2_cnt", 32'(fifo_count), 32'h4);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    for (int i = 0; i < 4; i++) drain_check("t2_order");
    chk("t2_cnt0", 32'(fifo_count), 32'h0);
    tick(1);

    // Fill to DEPTH, then push and pop in the same LOAD cycle.
    for (int i = 0; i < 8; i++) begin
      push(1'b0, 8'(8'h30 + i));
      exp_q.push_back(8'(8'h30 + i));
    end
    #1 chk("t3_full", 32'(fifo_count), 32'h8);
    req_a = 1'b1; data_a = 8'h40;
    tick(2);
    #1 chk("t3_no_ack_full", 32'(ack_a), 32'h0);
    ready4NewData = 1'b1;
    tick(3);
    #1;
    chk("t3_state_load", 32'(state_dbg), 32'h1);
    chk("t3_ack_on_pop", 32'(ack_a), 32'h1);
    tick(1);
    req_a = 1'b0;
    #1;
    chk("t3_pop_head", 32'(writeData), 32'(exp_q.pop_front()));
    chk("t3_cnt_stays", 32'(fifo_count), 32'h8);
    exp_q.push_back(8'h40);
    tick(1);
    ready4NewData = 1'b0;
    tick(3);
    for (int i = 0; i < 8; i++) drain_check("t3_order");
    chk("t3_cnt0", 32'(fifo_count), 32'h0);

    // Underrun on an empty FIFO, and it stays sticky.
    tick(1);
    pulse();
    chk("t4_pad", 32'(writeData), 32'hFF);
    chk("t4_underrun", 32'(underrun), 32'h1);
    tick(1);
    push(1'b1, 8'h55);
    pulse();
    chk("t4_wd55", 32'(writeData), 32'h55);
    chk("t4_sticky", 32'(underrun), 32'h1);

    // Done freezes everything; only reset exits.
    tick(1);
    push(1'b0, 8'h61); push(1'b1, 8'h62); push(1'b0, 8'h63);
    done = 1'b1;
    tick(1);
    #1 chk("t5_logfull_1edge", 32'(log_full), 32'h0);
    tick(1);
    #1 chk("t5_logfull_2edge", 32'(log_full), 32'h1);
    tick(2);
    #1 chk("t5_finished", 32'(state_dbg), 32'h2);
    req_a = 1'b1; data_a = 8'h70;
    #1 chk("t5_no_ack", 32'(ack_a), 32'h0);
    pulse();
    chk("t5_cnt_frozen", 32'(fifo_count), 32'h3);
    chk("t5_wd_frozen", 32'(writeData), 32'h55);
    req_a = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_cnt", 32'(fifo_count), 32'h0);
    chk("t5_rst_wd", 32'(writeData), 32'hFF);
    chk("t5_rst_underrun", 32'(underrun), 32'h0);
    chk("t5_rst_logfull", 32'(log_full), 32'h0);
    chk("t5_rst_state", 32'(state_dbg), 32'h0);

    // ready already high at reset release still counts as a rise.
    done = 1'b0;
    ready4NewData = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    #1 chk("t6_no_load_yet", 32'(underrun), 32'h0);
    tick(1);
    #1 chk("t6_rise_after_rst", 32'(underrun), 32'h1);
    ready4NewData = 1'b0;
    tick(3);

    // Source tagging (or pass-through when tagging is off).
    push(1'b1, 8'hFF);
    push(1'b0, 8'hFF);
    pulse();
    chk("t7_b_ff", 32'(writeData), 32'hFF);
    pulse();
    chk("t7_a_ff", 32'(writeData), 32'(EXP_A_FF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
